// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: memory ops, FSM states, byte-lane geometry
// and small decode helpers used by the stage and its load aligner.
package mem_stage_pkg;

  localparam logic [2:0] MEM_NONE = 3'd0;
  localparam logic [2:0] MEM_LB   = 3'd1;
  localparam logic [2:0] MEM_LBU  = 3'd2;
  localparam logic [2:0] MEM_LW   = 3'd3;
  localparam logic [2:0] MEM_SB   = 3'd4;
  localparam logic [2:0] MEM_SW   = 3'd5;

  localparam int unsigned LANE_W    = 8;
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [2:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == MEM_SB) || (op == MEM_SW);
  endfunction

  function automatic logic is_word(input logic [2:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

  // Big-endian lanes: byte 0 of the word lives in the most significant lane.
  function automatic logic [3:0] byte_sel(input logic [2:0] op, input logic [1:0] a);
    logic [3:0] sel;
    if (is_word(op)) begin
      sel = 4'b1111;
    end else begin
      case (a)
        2'd0:    sel = 4'b1000;
        2'd1:    sel = 4'b0100;
        2'd2:    sel = 4'b0010;
        default: sel = 4'b0001;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load formatter: picks the addressed big-endian byte and sign/zero extends it,
// or passes the whole word through for LW.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  memop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [LANE_W-1:0] byte_s;

  // Lane 0 (addr 0) is the most significant byte of the bus word.
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_s = rdata_i[31:24];
      2'd1:    byte_s = rdata_i[23:16];
      2'd2:    byte_s = rdata_i[15:8];
      default: byte_s = rdata_i[7:0];
    endcase
  end

  always_comb begin
    case (memop_i)
      MEM_LB:  data_o = {{24{byte_s[LANE_W-1]}}, byte_s};
      MEM_LBU: data_o = {24'd0, byte_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: holds one instruction, runs its data-bus access and
// forwards the write-back request, with a zero-bubble path for load data.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  memop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o
);

  state_e      state_q, state_d;
  logic [4:0]  wd_q, wd_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  memop_q, memop_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ldata_q, ldata_d;
  logic        mis_q, mis_d;

  logic        capture_s;
  logic        mis_in_s;
  logic        mem_in_s;
  logic        ack_s;
  logic [31:0] fmt_s;

  mem_stage_load_align u_load_align (
    .memop_i   (memop_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (dbus_rdata_i),
    .data_o    (fmt_s)
  );

  assign capture_s = !flush_i && !stall_i && !(state_q == ST_BUSY && !dbus_ack_i);
  assign mis_in_s  = is_word(memop_i) && (mem_addr_i[1:0] != 2'b00);
  assign mem_in_s  = is_load(memop_i) || is_store(memop_i);
  // An ack arriving together with a flush belongs to an abandoned access.
  assign ack_s     = dbus_ack_i && !flush_i;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    memop_d = memop_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ldata_d = ldata_q;
    mis_d   = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      wd_d    = 5'd0;
      wreg_d  = 1'b0;
      wdata_d = 32'd0;
      memop_d = MEM_NONE;
      addr_d  = 32'd0;
      data_d  = 32'd0;
      ldata_d = 32'd0;
    end else if (capture_s) begin
      wd_d    = wd_i;
      wreg_d  = wreg_i;
      wdata_d = wdata_i;
      memop_d = memop_i;
      addr_d  = mem_addr_i;
      data_d  = mem_data_i;
      mis_d   = mis_in_s;
      state_d = (mem_in_s && !mis_in_s) ? ST_BUSY : ST_IDLE;
    end else if (state_q == ST_BUSY && dbus_ack_i) begin
      // Completed while the pipeline is held: park the formatted result.
      state_d = ST_DONE;
      ldata_d = fmt_s;
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wd_q    <= 5'd0;
      wreg_q  <= 1'b0;
      wdata_q <= 32'd0;
      memop_q <= MEM_NONE;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      ldata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      memop_q <= memop_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ldata_q <= ldata_d;
      mis_q   <= mis_d;
    end
  end

  // Bus signals depend only on stage registers, so they stay stable across BUSY.
  always_comb begin
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = 32'd0;
    dbus_sel_o   = 4'd0;
    dbus_wdata_o = 32'd0;
    stallreq_o   = 1'b0;
    wd_o         = wd_q;
    wreg_o       = 1'b0;
    wdata_o      = wdata_q;
    misalign_o   = mis_q;
    case (state_q)
      ST_IDLE: begin
        wreg_o = (is_load(memop_q) || is_store(memop_q)) ? 1'b0 : wreg_q;
      end
      ST_BUSY: begin
        dbus_req_o   = 1'b1;
        dbus_we_o    = is_store(memop_q);
        dbus_addr_o  = {addr_q[31:2], 2'b00};
        dbus_sel_o   = byte_sel(memop_q, addr_q[1:0]);
        dbus_wdata_o = (memop_q == MEM_SB) ? {NUM_LANES{data_q[LANE_W-1:0]}} : data_q;
        stallreq_o   = !dbus_ack_i;
        if (ack_s && is_load(memop_q)) begin
          wreg_o  = wreg_q;
          wdata_o = fmt_s;
        end else begin
          wreg_o  = 1'b0;
        end
      end
      ST_DONE: begin
        wreg_o  = is_load(memop_q) ? wreg_q : 1'b0;
        wdata_o = ldata_q;
      end
      default: begin
        wreg_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized
// traffic, all compared against a transaction-level reference model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [2:0]  memop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        stall_i;
  logic        flush_i;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic        misalign_o;

  int vectors;
  int miscompares;

  // Reference model: what instruction sits in the stage and what it is waiting for.
  int          m_mode;   // 0 = nothing outstanding, 1 = waiting on bus, 2 = holding load result
  logic [2:0]  m_op;
  logic [4:0]  m_wd;
  logic        m_wreg;
  logic [31:0] m_wdata;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] m_hold;
  logic        m_first;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .memop_i      (memop_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_sel_o   (dbus_sel_o),
    .dbus_wdata_o (dbus_wdata_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .stallreq_o   (stallreq_o),
    .misalign_o   (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit t_load(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
  endfunction

  function automatic bit t_store(input logic [2:0] op);
    return (op == 3'd4) || (op == 3'd5);
  endfunction

  function automatic bit t_word(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd5);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] r);
    logic [31:0] b;
    if (op == 3'd3) return r;
    b = (r >> (8 * (3 - int'(a)))) & 32'h0000_00FF;
    if (op == 3'd1 && b >= 32'd128) return 32'hFFFF_FF00 | b;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_op    = 3'd0;
    m_wd    = 5'd0;
    m_wreg  = 1'b0;
    m_wdata = 32'd0;
    m_addr  = 32'd0;
    m_data  = 32'd0;
    m_hold  = 32'd0;
    m_first = 1'b0;
  endtask

  task automatic check_cycle();
    bit          e_req;
    bit          mem;
    logic        e_wreg;
    logic [31:0] b;
    e_req = (m_mode == 1);
    mem   = t_load(m_op) || t_store(m_op);
    b     = m_data & 32'h0000_00FF;
    chk("dbus_req", {31'd0, dbus_req_o}, {31'd0, e_req});
    chk("dbus_we", {31'd0, dbus_we_o}, {31'd0, e_req && t_store(m_op)});
    chk("dbus_addr", dbus_addr_o, e_req ? (m_addr & 32'hFFFF_FFFC) : 32'd0);
    chk("dbus_sel", {28'd0, dbus_sel_o},
        !e_req ? 32'd0 : (t_word(m_op) ? 32'd15 : (32'd8 >> m_addr[1:0])));
    chk("dbus_wdata", dbus_wdata_o,
        !e_req ? 32'd0 : ((m_op == 3'd4) ? b * 32'h0101_0101 : m_data));
    chk("stallreq", {31'd0, stallreq_o}, {31'd0, e_req && !dbus_ack_i});
    chk("misalign", {31'd0, misalign_o}, {31'd0, m_first});
    chk("wd", {27'd0, wd_o}, {27'd0, m_wd});
    if (m_mode == 0)      e_wreg = mem ? 1'b0 : m_wreg;
    else if (m_mode == 1) e_wreg = (t_load(m_op) && dbus_ack_i && !flush_i) ? m_wreg : 1'b0;
    else                  e_wreg = t_load(m_op) ? m_wreg : 1'b0;
    chk("wreg", {31'd0, wreg_o}, {31'd0, e_wreg});
    if (m_mode == 0 && !mem)
      chk("wdata_alu", wdata_o, m_wdata);
    else if (m_mode == 1 && t_load(m_op) && dbus_ack_i && !flush_i)
      chk("wdata_load", wdata_o, ref_load(m_op, m_addr[1:0], dbus_rdata_i));
    else if (m_mode == 2 && t_load(m_op))
      chk("wdata_held", wdata_o, m_hold);
  endtask

  task automatic model_step();
    bit mis;
    if (!rst) begin
      model_reset();
    end else if (flush_i) begin
      model_reset();
    end else if (!stall_i && !(m_mode == 1 && !dbus_ack_i)) begin
      m_op    = memop_i;
      m_wd    = wd_i;
      m_wreg  = wreg_i;
      m_wdata = wdata_i;
      m_addr  = mem_addr_i;
      m_data  = mem_data_i;
      mis     = t_word(memop_i) && (mem_addr_i[1:0] != 2'b00);
      m_first = mis;
      m_mode  = ((t_load(memop_i) || t_store(memop_i)) && !mis) ? 1 : 0;
    end else begin
      m_first = 1'b0;
      if (m_mode == 1 && dbus_ack_i) begin
        m_hold = ref_load(m_op, m_addr[1:0], dbus_rdata_i);
        m_mode = 2;
      end
    end
  endtask

  task automatic settle();
    #3;
    check_cycle();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_op(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    wd_i       = wd;
    wreg_i     = wreg;
    wdata_i    = wdata;
    memop_i    = op;
    mem_addr_i = addr;
    mem_data_i = data;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'd0;
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    model_reset();
    #1;
    check_cycle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ALU pass-through
    set_op(5'd3, 1'b1, 32'h1234_5678, 3'd0, 32'd0, 32'd0);
    settle(); edge_();
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    settle();
    chk("alu_wreg", {31'd0, wreg_o}, 32'd1);
    chk("alu_wdata", wdata_o, 32'h1234_5678);
    chk("alu_noreq", {31'd0, dbus_req_o}, 32'd0);
    edge_();

    // LB at 0x103, ack on the third BUSY cycle
    set_op(5'd7, 1'b1, 32'd0, 3'd1, 32'h0000_0103, 32'd0);
    dbus_rdata_i = 32'h0000_0080;
    settle(); edge_();
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    settle();
    chk("lb_sel", {28'd0, dbus_sel_o}, 32'b0001);
    chk("lb_stall1", {31'd0, stallreq_o}, 32'd1);
    edge_();
    settle();
    chk("lb_stall2", {31'd0, stallreq_o}, 32'd1);
    edge_();
    dbus_ack_i = 1'b1;
    settle();
    chk("lb_wdata", wdata_o, 32'hFFFF_FF80);
    chk("lb_wreg", {31'd0, wreg_o}, 32'd1);
    edge_();
    dbus_ack_i = 1'b0;

    // SW at 0x200, ack after one cycle
    set_op(5'd9, 1'b1, 32'd0, 3'd5, 32'h0000_0200, 32'hDEAD_BEEF);
    settle(); edge_();
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    dbus_ack_i = 1'b1;
    settle();
    chk("sw_we", {31'd0, dbus_we_o}, 32'd1);
    chk("sw_sel", {28'd0, dbus_sel_o}, 32'hF);
    chk("sw_data", dbus_wdata_o, 32'hDEAD_BEEF);
    chk("sw_wreg", {31'd0, wreg_o}, 32'd0);
    edge_();
    dbus_ack_i = 1'b0;

    // Misaligned LW at 0x102, held one extra cycle by stall
    set_op(5'd4, 1'b1, 32'd0, 3'd3, 32'h0000_0102, 32'd0);
    settle(); edge_();
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    stall_i = 1'b1;
    settle();
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_noreq", {31'd0, dbus_req_o}, 32'd0);
    chk("mis_wreg", {31'd0, wreg_o}, 32'd0);
    edge_();
    settle();
    chk("mis_once", {31'd0, misalign_o}, 32'd0);
    edge_();
    stall_i = 1'b0;
    settle(); edge_();

    // LW completing under stall, then held in DONE
    set_op(5'd5, 1'b1, 32'd0, 3'd3, 32'h0000_0300, 32'd0);
    settle(); edge_();
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    dbus_ack_i   = 1'b1;
    dbus_rdata_i = 32'hCAFE_F00D;
    stall_i      = 1'b1;
    settle(); edge_();
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = 32'h5555_AAAA;
    settle();
    chk("done_wdata", wdata_o, 32'hCAFE_F00D);
    chk("done_noreq", {31'd0, dbus_req_o}, 32'd0);
    edge_();
    stall_i = 1'b0;
    settle(); edge_();

    // Flush while BUSY, with an ack in the flush cycle
    set_op(5'd6, 1'b1, 32'd0, 3'd3, 32'h0000_0400, 32'd0);
    settle(); edge_();
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    settle();
    flush_i    = 1'b1;
    dbus_ack_i = 1'b1;
    settle(); edge_();
    flush_i    = 1'b0;
    dbus_ack_i = 1'b0;
    settle();
    chk("flush_noreq", {31'd0, dbus_req_o}, 32'd0);
    chk("flush_wreg", {31'd0, wreg_o}, 32'd0);
    edge_();

    // Reset in the middle of a BUSY access
    set_op(5'd8, 1'b1, 32'd0, 3'd1, 32'h0000_0500, 32'd0);
    settle(); edge_();
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    settle();
    rst = 1'b0;
    #1;
    model_reset();
    check_cycle();
    chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_op(5'd2, 1'b1, 32'hA5A5_0001, 3'd0, 32'd0, 32'd0);
    settle(); edge_();
    set_op(5'd0, 1'b0, 32'd0, 3'd0, 32'd0, 32'd0);
    settle(); edge_();

    // Randomized traffic; the bench acts as the bus and only acks outstanding accesses
    for (int i = 0; i < 400; i++) begin
      set_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
             3'($urandom_range(0, 7)),
             ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
             $urandom);
      stall_i      = ($urandom_range(0, 3) == 0);
      flush_i      = ($urandom_range(0, 11) == 0);
      dbus_ack_i   = (m_mode == 1) && ($urandom_range(0, 2) == 0);
      dbus_rdata_i = $urandom;
      settle();
      edge_();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
